// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: access width codes, FSM states and
// the alignment rule applied before a request may reach memory.
package mem_arbiter_pkg;

    localparam logic MEM_OP_WORD = 1'b0;
    localparam logic MEM_OP_BYTE = 1'b1;

    typedef enum logic [2:0] {
        ARB_IDLE   = 3'd0,
        ARB_ARB    = 3'd1,
        ARB_ACCESS = 3'd2,
        ARB_RESP   = 3'd3,
        ARB_ERR    = 3'd4
    } arb_state_e;

    // Only word accesses carry an alignment requirement; bytes may sit on any lane.
    function automatic logic is_misaligned(input logic op, input logic [1:0] addr_lo);
        return (op == MEM_OP_WORD) && (addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_rr2.sv
// Two-way winner selection: round-robin on ties, or port 0 always wins when FIXED_PRIO != 0.
// Holds the last_owner register that steers the round-robin tie-break.
module mem_arbiter_arb_rr2 #(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       owner,
    output logic       winner
);

    logic last_owner_q;

    // Reset to 1 so that port 0 takes the first tie after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_owner_q <= 1'b1;
        end else if (update) begin
            last_owner_q <= owner;
        end
    end

    always_comb begin
        winner = 1'b0;
        unique case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = (FIXED_PRIO != 0) ? 1'b0 : ~last_owner_q;
            default: winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single data-memory port between the CPU data path (port 0) and a DMA master
// (port 1); one transaction at a time, arbitrated in IDLE and sequenced by a fixed-latency FSM.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_op,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_done,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_op,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_done,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic              mem_op,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CntW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    arb_state_e        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              owner_q;
    logic              winner;
    logic              we_q, op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic              latch, capture, owner_update;
    logic              gnt_any, done_any, err_any;

    mem_arbiter_arb_rr2 #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({m1_req, m0_req}),
        .update(owner_update),
        .owner (owner_q),
        .winner(winner)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        latch        = 1'b0;
        capture      = 1'b0;
        owner_update = 1'b0;
        gnt_any      = 1'b0;
        done_any     = 1'b0;
        err_any      = 1'b0;
        mem_en       = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (m0_req || m1_req) begin
                    latch   = 1'b1;
                    state_d = ARB_ARB;
                end
            end
            ARB_ARB: begin
                gnt_any = 1'b1;
                if (is_misaligned(op_q, addr_q[1:0])) begin
                    state_d = ARB_ERR;
                end else begin
                    cnt_d   = CntW'(MEM_LAT - 1);
                    state_d = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                gnt_any = 1'b1;
                mem_en  = 1'b1;
                if (cnt_q == '0) begin
                    capture = ~we_q;
                    state_d = ARB_RESP;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            ARB_RESP: begin
                gnt_any      = 1'b1;
                done_any     = 1'b1;
                owner_update = 1'b1;
                state_d      = ARB_IDLE;
            end
            ARB_ERR: begin
                gnt_any      = 1'b1;
                done_any     = 1'b1;
                err_any      = 1'b1;
                owner_update = 1'b1;
                state_d      = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Request fields are captured only when leaving IDLE; later input changes are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            op_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (latch) begin
            owner_q <= winner;
            we_q    <= winner ? m1_we    : m0_we;
            op_q    <= winner ? m1_op    : m0_op;
            addr_q  <= winner ? m1_addr  : m0_addr;
            wdata_q <= winner ? m1_wdata : m0_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else if (capture) begin
            if (owner_q) begin
                rdata1_q <= mem_rdata;
            end else begin
                rdata0_q <= mem_rdata;
            end
        end
    end

    assign m0_gnt   = gnt_any  & ~owner_q;
    assign m1_gnt   = gnt_any  &  owner_q;
    assign m0_done  = done_any & ~owner_q;
    assign m1_done  = done_any &  owner_q;
    assign m0_err   = err_any  & ~owner_q;
    assign m1_err   = err_any  &  owner_q;
    assign m0_rdata = rdata0_q;
    assign m1_rdata = rdata1_q;

    assign mem_we    = mem_en & we_q;
    assign mem_op    = op_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MEM_LAT=1 round-robin, MEM_LAT=3 fixed priority)
// checked every cycle against a transaction-timeline model, plus directed vectors.
module tb_mem_arbiter;

    localparam int N = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req   [N][2];
    logic        we    [N][2];
    logic        op    [N][2];
    logic [31:0] addr  [N][2];
    logic [31:0] wdata [N][2];
    logic        gnt   [N][2];
    logic        done  [N][2];
    logic        err   [N][2];
    logic [31:0] rdata [N][2];
    logic        mem_en    [N];
    logic        mem_we    [N];
    logic        mem_op    [N];
    logic [31:0] mem_addr  [N];
    logic [31:0] mem_wdata [N];
    logic [31:0] mem_rdata [N];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    assign mem_rdata[0] = mem_fn(mem_addr[0]);
    assign mem_rdata[1] = mem_fn(mem_addr[1]);

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .FIXED_PRIO(0)) dut0 (
        .clk(clk), .reset(reset),
        .m0_req(req[0][0]), .m0_we(we[0][0]), .m0_op(op[0][0]), .m0_addr(addr[0][0]),
        .m0_wdata(wdata[0][0]), .m0_gnt(gnt[0][0]), .m0_done(done[0][0]), .m0_err(err[0][0]),
        .m0_rdata(rdata[0][0]),
        .m1_req(req[0][1]), .m1_we(we[0][1]), .m1_op(op[0][1]), .m1_addr(addr[0][1]),
        .m1_wdata(wdata[0][1]), .m1_gnt(gnt[0][1]), .m1_done(done[0][1]), .m1_err(err[0][1]),
        .m1_rdata(rdata[0][1]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_op(mem_op[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .FIXED_PRIO(1)) dut1 (
        .clk(clk), .reset(reset),
        .m0_req(req[1][0]), .m0_we(we[1][0]), .m0_op(op[1][0]), .m0_addr(addr[1][0]),
        .m0_wdata(wdata[1][0]), .m0_gnt(gnt[1][0]), .m0_done(done[1][0]), .m0_err(err[1][0]),
        .m0_rdata(rdata[1][0]),
        .m1_req(req[1][1]), .m1_we(we[1][1]), .m1_op(op[1][1]), .m1_addr(addr[1][1]),
        .m1_wdata(wdata[1][1]), .m1_gnt(gnt[1][1]), .m1_done(done[1][1]), .m1_err(err[1][1]),
        .m1_rdata(rdata[1][1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_op(mem_op[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
    );

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic bit fp_of(input int i);
        return (i == 1);
    endfunction

    // Model: each transaction is a timeline anchored at the cycle its request was sampled.
    bit          busy   [N];
    bit          own    [N];
    int          t0     [N];
    bit          merr   [N];
    bit          mwe    [N];
    bit          mop    [N];
    logic [31:0] maddr  [N];
    logic [31:0] mwdata [N];
    bit          last   [N];
    logic [31:0] mrd    [N][2];
    int          cyc;
    int          checks;
    int          errors;
    int          pend   [N][2];
    int          cool   [N][2];

    function automatic int end_off(input int i);
        return merr[i] ? 2 : lat_of(i) + 2;
    endfunction

    function automatic bit active(input int i);
        return busy[i] && (cyc > t0[i]) && (cyc <= t0[i] + end_off(i));
    endfunction

    function automatic bit exp_done(input int i, input int p);
        return active(i) && (int'(own[i]) == p) && (cyc == t0[i] + end_off(i));
    endfunction

    function automatic bit exp_en(input int i);
        return active(i) && !merr[i] && (cyc >= t0[i] + 2) && (cyc <= t0[i] + lat_of(i) + 1);
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d cycle %0d: got %h expected %h", name, i, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            busy[i]   = 1'b0;
            last[i]   = 1'b1;
            mrd[i][0] = '0;
            mrd[i][1] = '0;
        end
    endtask

    task automatic model_sample(input int i);
        int w;
        if (!active(i) && (req[i][0] || req[i][1])) begin
            if (req[i][0] && req[i][1]) w = fp_of(i) ? 0 : (last[i] ? 0 : 1);
            else w = req[i][1] ? 1 : 0;
            busy[i]   = 1'b1;
            own[i]    = w[0];
            t0[i]     = cyc;
            mwe[i]    = we[i][w];
            mop[i]    = op[i][w];
            maddr[i]  = addr[i][w];
            mwdata[i] = wdata[i][w];
            merr[i]   = (op[i][w] == 1'b0) && (addr[i][w] % 4 != 0);
        end
    endtask

    task automatic model_advance(input int i);
        if (busy[i] && cyc == t0[i] + end_off(i)) begin
            if (!merr[i] && !mwe[i]) mrd[i][own[i]] = mem_fn(maddr[i]);
            last[i] = own[i];
        end
    endtask

    task automatic check_outputs(input int i);
        bit en;
        en = exp_en(i);
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("gnt%0d", p), i, 32'(gnt[i][p]),
                32'(active(i) && int'(own[i]) == p));
            chk($sformatf("done%0d", p), i, 32'(done[i][p]), 32'(exp_done(i, p)));
            chk($sformatf("err%0d", p), i, 32'(err[i][p]), 32'(exp_done(i, p) && merr[i]));
            chk($sformatf("rdata%0d", p), i, rdata[i][p], mrd[i][p]);
        end
        chk("mem_en", i, 32'(mem_en[i]), 32'(en));
        chk("mem_we", i, 32'(mem_we[i]), 32'(en && mwe[i]));
        if (en) begin
            chk("mem_addr", i, mem_addr[i], maddr[i]);
            chk("mem_op", i, 32'(mem_op[i]), 32'(mop[i]));
            if (mwe[i]) chk("mem_wdata", i, mem_wdata[i], mwdata[i]);
        end
    endtask

    task automatic tick();
        if (!reset) for (int i = 0; i < N; i++) model_sample(i);
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            model_advance(i);
            check_outputs(i);
        end
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < N; i++) begin
            for (int p = 0; p < 2; p++) begin
                req[i][p]   = 1'b0;
                we[i][p]    = 1'b0;
                op[i][p]    = 1'b0;
                addr[i][p]  = '0;
                wdata[i][p] = '0;
                pend[i][p]  = 0;
                cool[i][p]  = 0;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        model_reset();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic run_txn(input int i, input int p, input bit t_we, input bit t_op,
                           input logic [31:0] t_addr, input logic [31:0] t_wdata,
                           output int lat_seen, output bit err_seen,
                           output logic [31:0] rd_seen, output int en_cnt);
        int ts;
        req[i][p]   = 1'b1;
        we[i][p]    = t_we;
        op[i][p]    = t_op;
        addr[i][p]  = t_addr;
        wdata[i][p] = t_wdata;
        ts          = cyc;
        lat_seen    = -1;
        err_seen    = 1'b0;
        rd_seen     = '0;
        en_cnt      = 0;
        for (int k = 0; k < 20 && lat_seen < 0; k++) begin
            tick();
            // Scramble the request after it has been latched; the DUT must ignore it.
            if (k == 0) begin
                addr[i][p]  = t_addr ^ 32'hFFFF_FFF0;
                wdata[i][p] = ~t_wdata;
            end
            if (mem_en[i]) en_cnt++;
            if (done[i][p]) begin
                lat_seen  = cyc - ts;
                err_seen  = err[i][p];
                rd_seen   = rdata[i][p];
                req[i][p] = 1'b0;
            end
        end
        req[i][p] = 1'b0;
        tick();
    endtask

    task automatic drive(input int i, input int p);
        bit          granted;
        logic [31:0] a;
        granted = active(i) && int'(own[i]) == p;
        if (pend[i][p] != 0) begin
            if (exp_done(i, p)) begin
                pend[i][p] = 0;
                cool[i][p] = 1 + int'($urandom_range(2));
                req[i][p]  = 1'b0;
            end else if (!granted && $urandom_range(9) == 0) begin
                pend[i][p] = 0;
                cool[i][p] = 1;
                req[i][p]  = 1'b0;
            end else if (granted) begin
                req[i][p]   = 1'($urandom_range(1));
                we[i][p]    = 1'($urandom_range(1));
                op[i][p]    = 1'($urandom_range(1));
                addr[i][p]  = $urandom;
                wdata[i][p] = $urandom;
            end else begin
                req[i][p] = 1'b1;
            end
        end else if (cool[i][p] > 0) begin
            cool[i][p]--;
            req[i][p] = 1'b0;
        end else if ($urandom_range(2) == 0) begin
            a = $urandom;
            if ($urandom_range(1) == 0) a[1:0] = 2'b00;
            pend[i][p]  = 1;
            req[i][p]   = 1'b1;
            we[i][p]    = 1'($urandom_range(1));
            op[i][p]    = 1'($urandom_range(1));
            addr[i][p]  = a;
            wdata[i][p] = $urandom;
        end else begin
            req[i][p] = 1'b0;
        end
    endtask

    typedef struct {
        int          inst;
        int          port;
        bit          we;
        bit          op;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          exp_lat;
        int          exp_en;
        bit          exp_err;
        bit          chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t        vecs [8];
    int          lat_seen;
    int          en_cnt;
    bit          err_seen;
    logic [31:0] rd_seen;
    int          ord [N][$];
    int          m1_gnt_cnt;
    bit          seen;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        reset  = 1'b0;
        clear_inputs();
        model_reset();
        #2 reset = 1'b1;

        //           inst port we    op    addr          wdata          lat en err   rd    exp_rd
        vecs[0] = '{0, 0, 1'b0, 1'b0, 32'h10,  32'h0,        3, 1, 1'b0, 1'b1, 32'hDEADBEEF};
        vecs[1] = '{1, 1, 1'b1, 1'b0, 32'h40,  32'h12345678, 5, 3, 1'b0, 1'b1, 32'h0};
        vecs[2] = '{0, 0, 1'b0, 1'b0, 32'h13,  32'h0,        2, 0, 1'b1, 1'b1, 32'hDEADBEEF};
        vecs[3] = '{0, 0, 1'b0, 1'b1, 32'h13,  32'h0,        3, 1, 1'b0, 1'b1, mem_fn(32'h13)};
        vecs[4] = '{1, 0, 1'b0, 1'b0, 32'h200, 32'h0,        5, 3, 1'b0, 1'b1, mem_fn(32'h200)};
        vecs[5] = '{1, 1, 1'b1, 1'b1, 32'h7,   32'hA5,       5, 3, 1'b0, 1'b1, 32'h0};
        vecs[6] = '{0, 1, 1'b0, 1'b0, 32'h104, 32'h0,        3, 1, 1'b0, 1'b1, mem_fn(32'h104)};
        vecs[7] = '{1, 1, 1'b0, 1'b0, 32'h42,  32'h0,        2, 0, 1'b1, 1'b1, 32'h0};

        do_reset();
        for (int v = 0; v < 8; v++) begin
            run_txn(vecs[v].inst, vecs[v].port, vecs[v].we, vecs[v].op, vecs[v].addr,
                    vecs[v].wdata, lat_seen, err_seen, rd_seen, en_cnt);
            chk($sformatf("vec%0d latency", v), vecs[v].inst, lat_seen, vecs[v].exp_lat);
            chk($sformatf("vec%0d mem_en cycles", v), vecs[v].inst, en_cnt, vecs[v].exp_en);
            chk($sformatf("vec%0d err", v), vecs[v].inst, 32'(err_seen), 32'(vecs[v].exp_err));
            if (vecs[v].chk_rd)
                chk($sformatf("vec%0d rdata", v), vecs[v].inst, rd_seen, vecs[v].exp_rd);
        end

        // Both ports held on both instances: round-robin alternates, fixed priority starves m1.
        do_reset();
        for (int i = 0; i < N; i++) begin
            for (int p = 0; p < 2; p++) begin
                req[i][p]  = 1'b1;
                addr[i][p] = 32'h20 + 32'(4 * p);
            end
        end
        m1_gnt_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (gnt[1][1]) m1_gnt_cnt++;
            for (int i = 0; i < N; i++)
                for (int p = 0; p < 2; p++)
                    if (done[i][p]) ord[i].push_back(p);
        end
        clear_inputs();
        for (int k = 0; k < 8; k++) tick();
        chk("rr served count", 0, 32'(ord[0].size() >= 4), 32'd1);
        chk("fixed served count", 1, 32'(ord[1].size() >= 3), 32'd1);
        if (ord[0].size() >= 4)
            for (int k = 0; k < 4; k++) chk($sformatf("rr order %0d", k), 0, ord[0][k], k % 2);
        if (ord[1].size() >= 3)
            for (int k = 0; k < 3; k++) chk($sformatf("fixed order %0d", k), 1, ord[1][k], 0);
        chk("fixed m1 never granted", 1, m1_gnt_cnt, 0);

        // Reset while inst1 is mid-access: mem_en drops at once, no done follows.
        do_reset();
        req[1][1]  = 1'b1;
        addr[1][1] = 32'h80;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            tick();
            seen = mem_en[1];
        end
        chk("reach access", 1, 32'(seen), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        chk("mem_en after async reset", 1, 32'(mem_en[1]), 32'd0);
        chk("gnt after async reset", 1, 32'(gnt[1][1]), 32'd0);
        chk("done after async reset", 1, 32'(done[1][1]), 32'd0);
        clear_inputs();
        model_reset();
        tick();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        for (int i = 0; i < N; i++) begin
            req[i][0] = 1'b1;
            req[i][1] = 1'b1;
        end
        tick();
        for (int i = 0; i < N; i++) begin
            chk("first tie m0 gnt", i, 32'(gnt[i][0]), 32'd1);
            chk("first tie m1 gnt", i, 32'(gnt[i][1]), 32'd0);
        end
        clear_inputs();
        for (int k = 0; k < 10; k++) tick();

        // Randomised requesters obeying the handshake rules.
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < N; i++)
                for (int p = 0; p < 2; p++) drive(i, p);
            tick();
        end
        clear_inputs();
        for (int k = 0; k < 10; k++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
